fifo: RTL and testbench

- Single-clock synchronous FIFO buffer with parameterised data width and depth.
- Writes are accepted when not full; reads are accepted when not empty.
- Status flags `full` and `empty` are provided for producer/consumer flow control.
- Used as a small elastic buffer between pixel-stream stages, e.g. in the grayscale pipeline.

---
 rtl/fifo.sv | 69 ++++++
 tb/tb_fifo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with a registered read port and count-decoded flags.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  WR,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] dataOut,
  input  logic                  RD,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  wr_accept, rd_accept;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign wr_accept = WR & ~full;
  assign rd_accept = RD & ~empty;
  assign dataOut   = data_out_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_accept)
      wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    if (rd_accept)
      rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (rd_accept)
        data_out_reg <= mem_reg[rd_ptr_reg];
    end
  end

  // Storage carries no reset so it can map onto block RAM; reset only gates the write.
  always_ff @(posedge clk) begin
    if (!rstn && wr_accept)
      mem_reg[wr_ptr_reg] <= dataIn;
  end

endmodule

// File: tb/tb_fifo.sv
// Directed, table-driven check of the fifo: every step drives one edge and
// compares dataOut/full/empty against hand-computed values.
module tb_fifo;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] dataIn;
  logic          WR;
  logic          full;
  logic [DW-1:0] dataOut;
  logic          RD;
  logic          empty;

  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_full;
    logic          exp_empty;
    string         name;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  int   tests  = 0;
  int   fails  = 0;
  int   step   = 0;

  fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .dataIn  (dataIn),
    .WR      (WR),
    .full    (full),
    .dataOut (dataOut),
    .RD      (RD),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic add(ref vec_t q[$], input logic rst, input logic wr, input logic rd,
                     input logic [DW-1:0] din, input logic [DW-1:0] ed,
                     input logic ef, input logic ee, input string name);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
    v.exp_dout = ed; v.exp_full = ef; v.exp_empty = ee; v.name = name;
    q.push_back(v);
  endtask

  task automatic apply(input logic rst, input logic wr, input logic rd,
                       input logic [DW-1:0] din, input logic [DW-1:0] ed,
                       input logic ef, input logic ee, input string name);
    rstn = rst; WR = wr; RD = rd; dataIn = din;
    @(posedge clk);
    #1;
    tests++;
    step++;
    if (dataOut !== ed || full !== ef || empty !== ee) begin
      fails++;
      $display("FAIL %s step %0d: got dataOut=%02h full=%b empty=%b, expected dataOut=%02h full=%b empty=%b",
               name, step, dataOut, full, empty, ed, ef, ee);
    end else begin
      $display("[TB] step %0d %s: rst=%b wr=%b rd=%b din=%02h -> dataOut=%02h full=%b empty=%b ok",
               step, name, rst, wr, rd, din, dataOut, full, empty);
    end
  endtask

  logic [DW-1:0] prev;

  initial begin
    rstn = 1'b1; WR = 1'b1; RD = 1'b1; dataIn = 8'hAA;

    // Phase A: reset, fill, overfill, drain, underflow read
    for (int i = 0; i < 3; i++) add(vecs_a, 1, 1, 1, 8'hAA, 8'h00, 0, 1, "reset");
    add(vecs_a, 0, 1, 0, 8'h00, 8'h00, 0, 0, "fill0");
    add(vecs_a, 0, 1, 0, 8'h01, 8'h00, 0, 0, "fill1");
    add(vecs_a, 0, 1, 0, 8'h02, 8'h00, 0, 0, "fill2");
    add(vecs_a, 0, 1, 0, 8'h03, 8'h00, 1, 0, "fill3");
    add(vecs_a, 0, 1, 0, 8'h04, 8'h00, 1, 0, "overfill");
    add(vecs_a, 0, 0, 1, 8'h00, 8'h00, 0, 0, "drain0");
    add(vecs_a, 0, 0, 1, 8'h00, 8'h01, 0, 0, "drain1");
    add(vecs_a, 0, 0, 1, 8'h00, 8'h02, 0, 0, "drain2");
    add(vecs_a, 0, 0, 1, 8'h00, 8'h03, 0, 1, "drain3");
    add(vecs_a, 0, 0, 1, 8'h00, 8'h03, 0, 1, "underflow");

    // Phase B: simultaneous ops, full/empty corner cases, reset mid-fill
    add(vecs_b, 0, 1, 0, 8'h05, 8'h13, 0, 0, "sim_w5");
    add(vecs_b, 0, 1, 0, 8'h06, 8'h13, 0, 0, "sim_w6");
    add(vecs_b, 0, 1, 1, 8'h07, 8'h05, 0, 0, "sim_wr");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h06, 0, 0, "sim_r6");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h07, 0, 1, "sim_r7");
    add(vecs_b, 0, 1, 0, 8'h00, 8'h07, 0, 0, "f_w0");
    add(vecs_b, 0, 1, 0, 8'h01, 8'h07, 0, 0, "f_w1");
    add(vecs_b, 0, 1, 0, 8'h02, 8'h07, 0, 0, "f_w2");
    add(vecs_b, 0, 1, 0, 8'h03, 8'h07, 1, 0, "f_w3");
    add(vecs_b, 0, 1, 1, 8'h09, 8'h00, 0, 0, "full_wr");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h01, 0, 0, "full_r1");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h02, 0, 0, "full_r2");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h03, 0, 1, "full_r3");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h03, 0, 1, "no9");
    add(vecs_b, 0, 1, 1, 8'h08, 8'h03, 0, 0, "empty_wr");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h08, 0, 1, "empty_r8");
    add(vecs_b, 0, 1, 0, 8'h01, 8'h08, 0, 0, "mid_w1");
    add(vecs_b, 0, 1, 0, 8'h02, 8'h08, 0, 0, "mid_w2");
    add(vecs_b, 1, 1, 0, 8'h77, 8'h00, 0, 1, "mid_rst");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h00, 0, 1, "post_rst_rd");
    add(vecs_b, 0, 1, 0, 8'h55, 8'h00, 0, 0, "post_rst_w");
    add(vecs_b, 0, 0, 1, 8'h00, 8'h55, 0, 1, "post_rst_r");

    foreach (vecs_a[i])
      apply(vecs_a[i].rst, vecs_a[i].wr, vecs_a[i].rd, vecs_a[i].din,
            vecs_a[i].exp_dout, vecs_a[i].exp_full, vecs_a[i].exp_empty, vecs_a[i].name);

    // Interleaved write/read pairs walk both pointers through several wraps
    prev = 8'h03;
    for (int i = 10; i < 20; i++) begin
      apply(0, 1, 0, DW'(i), prev, 0, 0, "wrap_w");
      apply(0, 0, 1, 8'h00, DW'(i), 0, 1, "wrap_r");
      prev = DW'(i);
    end

    foreach (vecs_b[i])
      apply(vecs_b[i].rst, vecs_b[i].wr, vecs_b[i].rd, vecs_b[i].din,
            vecs_b[i].exp_dout, vecs_b[i].exp_full, vecs_b[i].exp_empty, vecs_b[i].name);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
